mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Sequencer in front of the E-stage multiply/divide unit. It decides when an E-stage MDU operation may be issued and tracks the multi-cycle mult/div latency.
- Raises the D-stage stall for MDU-dependent instructions and pulses the HI/LO commit strobe.
- Gates all issue with the exception/interrupt request (req), so a flushed instruction never starts or writes HI/LO.
- Sits between the hazard unit and the MDU datapath, and exposes a stall-cycle performance counter.

Parameters:
- TYPE_W, 5, width of the MDU op code.
- MUL_LAT, 5, cycles from mult/multu issue to HI/LO commit (counter load value).
- DIV_LAT, 10, cycles from div/divu issue to HI/LO commit.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- E_MDUType  in  TYPE_W  MDU op of the instruction in E; NONE when not an MDU op.
- E_valid  in  1  E holds a real, non-bubble instruction.
- req  in  1  exception/interrupt flush request this cycle.
- D_useMDU  in  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- issue_type  out  TYPE_W  op forwarded to the MDU datapath this cycle; NONE when not issued.
- start  out  1  a mult/multu/div/divu is issued this cycle.
- busy  out  1  long operation in flight.
- hilo_commit  out  1  one-cycle pulse: temp results are written to HI/LO this cycle.
- D_stall  out  1  stall D/freeze F.
- stall_cnt  out  CNT_W  number of cycles D_stall was caused by the MDU.

Behaviour:
- Op encodings (package): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Any other value is treated as NONE.
- States: IDLE, RUN. Down-counter cnt is ceil(log2(DIV_LAT+1)) bits wide.
- Issue condition: issue_ok = E_valid & !req & (state==IDLE). issue_type = issue_ok ? E_MDUType : NONE (combinational). mfhi/mflo/mthi/mtlo are forwarded under the same gate.
- start = issue_ok & op in {MULT, MULTU, DIV, DIVU}.
- IDLE -> RUN on start. cnt loads MUL_LAT for mult/multu and DIV_LAT for div/divu.
- RUN: cnt decrements each cycle. When cnt==1, hilo_commit=1 (combinational from registered state), and on the next edge the state returns to IDLE with cnt=0.
- busy = (state==RUN). busy is registered, so it is high from the cycle after start through the hilo_commit cycle inclusive.
- Latency: start at cycle T, hilo_commit at T+LAT, a new issue is allowed at T+LAT+1.
- D_stall = D_useMDU & (start | busy), combinational.
- stall_cnt increments on every cycle where D_stall=1 and wraps modulo 2^CNT_W.
- req mid-operation: an op already in RUN is not cancelled and completes and commits normally. req only blocks new issue that cycle, including mthi/mtlo.
- req in the same cycle as an issue candidate: no issue, start=0, state stays IDLE.
- E_valid=1 with a long op while in RUN: not issued. The hazard unit holds it in E via D_stall, which it already asserted in the preceding cycle.
- Illegal encoding: issue_type is forced to NONE and has no state effect.
- Reset (takes priority over everything, including mid-RUN): state=IDLE, cnt=0, stall_cnt=0.
- Outputs after reset: busy=0, start=0, hilo_commit=0, D_stall=0 unless D_useMDU & a combinational start, issue_type=NONE when E_valid=0.

Decomposition:
- Shared constants file (const.v): MDUType_* op encodings, MUL_LAT/DIV_LAT defaults, and the IDLE/RUN state codes.
- One natural sub-module, mdu_lat_counter: loadable down-counter with a load value, a cnt==1 "last" flag and an active flag. The FSM/gating logic stays in the top module.

Test Plan:
- MULT issue at cycle 10 (E_valid=1, req=0) -> start=1 at 10; busy=1 at 11..15; hilo_commit=1 only at 15; busy=0 at 16.
- DIVU at cycle 20 with D_useMDU=1 (mflo) -> D_stall=1 at 20..30, hilo_commit at 30, D_stall=0 at 31, stall_cnt=11.
- MULT presented with req=1 -> issue_type=0, start=0, busy stays 0, no hilo_commit within 12 cycles.
- DIV issued, then req=1 at 3 cycles after issue -> the operation still commits exactly 10 cycles after issue; MTHI presented during the req cycle gives issue_type=0.
- Back-to-back: MULT at cycle 0 and MULTU waiting in E -> MULTU is issued at cycle 6 (start=1), not earlier; encoding 9 with E_valid=1 in IDLE gives issue_type=0.
- reset=1 at cycle 4 of a DIV -> next cycle busy=0, stall_cnt=0, no hilo_commit ever fires for that DIV.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU op encodings, latency defaults and sequencer state codes.
// Helper predicates classify raw op codes, including out-of-range values.
package mdu_issue_ctrl_pkg;

  localparam int OP_W        = 5;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [OP_W-1:0] {
    MDU_NONE  = 5'd0,
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MFHI  = 5'd5,
    MDU_MFLO  = 5'd6,
    MDU_MTHI  = 5'd7,
    MDU_MTLO  = 5'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_legal(input int unsigned op);
    return op <= 32'(MDU_MTLO);
  endfunction

  function automatic logic is_long(input int unsigned op);
    return (op >= 32'(MDU_MULT)) && (op <= 32'(MDU_DIVU));
  endfunction

  function automatic logic is_div(input int unsigned op);
    return (op == 32'(MDU_DIV)) || (op == 32'(MDU_DIVU));
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat.sv
// Loadable latency down-counter for the MDU sequencer.
// Flags the final count so commit can be decoded from registered state.
module mdu_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         active
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last   = (cnt == W'(1));
  assign active = (cnt != '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue sequencer: gates issue on flush, tracks
// mult/div latency, raises D stall and counts MDU stall cycles.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int TYPE_W  = 5,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TYPE_W-1:0] E_MDUType,
  input  logic              E_valid,
  input  logic              req,
  input  logic              D_useMDU,
  output logic [TYPE_W-1:0] issue_type,
  output logic              start,
  output logic              busy,
  output logic              hilo_commit,
  output logic              D_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int LW = $clog2(DIV_LAT + 1);

  mdu_state_e  state;
  mdu_state_e  state_nxt;
  logic        issue_ok;
  logic        legal;
  logic        long_op;
  logic        div_op;
  logic [LW-1:0] cnt;
  logic [LW-1:0] load_val;
  logic        last;
  logic        active;

  assign legal    = is_legal(32'(E_MDUType));
  assign long_op  = is_long(32'(E_MDUType));
  assign div_op   = is_div(32'(E_MDUType));
  assign issue_ok = E_valid & ~req & (state == S_IDLE);

  assign issue_type = (issue_ok && legal) ? E_MDUType : '0;
  assign start      = issue_ok & long_op;
  assign load_val   = div_op ? LW'(DIV_LAT) : LW'(MUL_LAT);

  mdu_lat_counter #(
    .W (LW)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (load_val),
    .cnt      (cnt),
    .last     (last),
    .active   (active)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A RUN state with an empty counter is recovered to IDLE
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    hilo_commit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        hilo_commit = last;
        if (last || !active) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign D_stall = D_useMDU & (start | busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (D_stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl against a cycle-timestamp
// model: an op started at cycle T is busy over (T, T+LAT] and commits at T+LAT.
module tb_mdu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  E_MDUType;
  logic        E_valid;
  logic        req;
  logic        D_useMDU;
  logic [4:0]  issue_type;
  logic        start;
  logic        busy;
  logic        hilo_commit;
  logic        D_stall;
  logic [31:0] stall_cnt;

  mdu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .E_MDUType   (E_MDUType),
    .E_valid     (E_valid),
    .req         (req),
    .D_useMDU    (D_useMDU),
    .issue_type  (issue_type),
    .start       (start),
    .busy        (busy),
    .hilo_commit (hilo_commit),
    .D_stall     (D_stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int          cyc = 0;
  bit          in_flight = 0;
  int          t0 = 0;
  int          lat = 0;
  logic [31:0] m_scnt = '0;

  logic [4:0]  e_issue;
  bit          e_start, e_busy, e_commit, e_stall;
  logic [4:0]  cur_op;
  bit          cur_rs;

  function automatic logic [40:0] obs_vec();
    return {issue_type, start, busy, hilo_commit, D_stall, stall_cnt};
  endfunction

  function automatic logic [40:0] exp_vec();
    return {e_issue, e_start, e_busy, e_commit, e_stall, m_scnt};
  endfunction

  task automatic tick(input logic [4:0] op, input bit ev,
                      input bit rq, input bit du, input bit rs);
    bit ok;
    E_MDUType = op;
    E_valid   = ev;
    req       = rq;
    D_useMDU  = du;
    reset     = rs;
    cur_op    = op;
    cur_rs    = rs;
    @(negedge clk);
    e_busy   = in_flight && (cyc > t0) && (cyc <= t0 + lat);
    e_commit = in_flight && (cyc == t0 + lat);
    ok       = ev && !rq && !e_busy;
    e_issue  = (ok && op <= 5'd8) ? op : 5'd0;
    e_start  = ok && (op >= 5'd1) && (op <= 5'd4);
    e_stall  = du && (e_start || e_busy);
  endtask

  task automatic adv();
    @(posedge clk);
    if (cur_rs) begin
      in_flight = 0;
      m_scnt    = '0;
    end else begin
      if (e_stall) m_scnt = m_scnt + 1;
      if (e_commit) in_flight = 0;
      if (e_start) begin
        in_flight = 1;
        t0        = cyc;
        lat       = (cur_op >= 5'd3) ? 10 : 5;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL reset got=%h want=%h", obs_vec(), exp_vec());
      end else passed++;
      adv();
    end
    tick(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({busy, start, hilo_commit, D_stall, issue_type, stall_cnt} !== '0) begin
      $display("FAIL reset_idle got=%b%b%b%b %h %h want=0",
               busy, start, hilo_commit, D_stall, issue_type, stall_cnt);
    end else passed++;
    adv();
  endtask

  task automatic test_mult();
    int sa = -1;
    int ca = -1;
    int bn = 0;
    for (int i = 0; i < 10; i++) begin
      tick(i == 1 ? 5'd1 : 5'd0, i == 1, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL mult cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (start) sa = i;
      if (hilo_commit) ca = i;
      if (busy) bn++;
      adv();
    end
    total++;
    if (sa != 1 || ca != 6 || bn != 5) begin
      $display("FAIL mult_lat got start=%0d commit=%0d busy=%0d want 1/6/5",
               sa, ca, bn);
    end else passed++;
  endtask

  task automatic test_divu_stall();
    logic [31:0] s0 = '0;
    int ca = -1;
    for (int i = 0; i < 12; i++) begin
      tick(i == 0 ? 5'd4 : 5'd0, i == 0, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL divu cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (i == 0) s0 = stall_cnt;
      if (hilo_commit) ca = i;
      if (i == 11) begin
        total++;
        if (D_stall !== 1'b0 || stall_cnt - s0 !== 32'd11 || ca != 10) begin
          $display("FAIL divu_stall got stall=%b delta=%0d commit=%0d want 0/11/10",
                   D_stall, stall_cnt - s0, ca);
        end else passed++;
      end
      adv();
    end
  endtask

  task automatic test_req_block();
    int hits = 0;
    for (int i = 0; i < 13; i++) begin
      tick(i == 0 ? 5'd1 : 5'd0, i == 0, i == 0, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL req_block cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (start || busy || hilo_commit || issue_type != 0) hits++;
      adv();
    end
    total++;
    if (hits != 0) begin
      $display("FAIL req_block_quiet got=%0d active cycles want=0", hits);
    end else passed++;
  endtask

  task automatic test_req_mid();
    int ca = -1;
    logic [4:0] op;
    for (int i = 0; i < 12; i++) begin
      op = (i == 0) ? 5'd3 : (i == 3) ? 5'd7 : 5'd0;
      tick(op, i == 0 || i == 3, i == 3, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL req_mid cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (i == 3) begin
        total++;
        if (issue_type !== 5'd0 || busy !== 1'b1) begin
          $display("FAIL req_mthi got issue=%0d busy=%b want 0/1",
                   issue_type, busy);
        end else passed++;
      end
      if (hilo_commit) ca = i;
      adv();
    end
    total++;
    if (ca != 10) begin
      $display("FAIL req_mid_commit got=%0d want=10", ca);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    int mu = -1;
    logic [4:0] op;
    for (int i = 0; i < 13; i++) begin
      op = (i == 0) ? 5'd1 : (mu < 0) ? 5'd2 : 5'd0;
      tick(op, op != 5'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (start && i > 0) mu = i;
      adv();
    end
    total++;
    if (mu != 6) begin
      $display("FAIL b2b_issue got=%0d want=6", mu);
    end else passed++;
    tick(5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (issue_type !== 5'd0 || start !== 1'b0 || D_stall !== 1'b0) begin
      $display("FAIL illegal got issue=%0d start=%b stall=%b want 0/0/0",
               issue_type, start, D_stall);
    end else passed++;
    adv();
    tick(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL illegal_state got busy=%b want 0", busy);
    end else passed++;
    adv();
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    for (int i = 0; i < 18; i++) begin
      tick(i == 0 ? 5'd3 : 5'd0, i == 0, 1'b0, 1'b1, i == 4);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL rst_mid cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      if (i == 5) begin
        total++;
        if (busy !== 1'b0 || stall_cnt !== 32'd0) begin
          $display("FAIL rst_mid_clear got busy=%b cnt=%0d want 0/0",
                   busy, stall_cnt);
        end else passed++;
      end
      if (hilo_commit) hits++;
      adv();
    end
    total++;
    if (hits != 0) begin
      $display("FAIL rst_mid_commit got=%0d commits want=0", hits);
    end else passed++;
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 11));
      tick(op, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end else passed++;
      adv();
    end
  endtask

  initial begin
    reset     = 1'b1;
    E_MDUType = '0;
    E_valid   = 1'b0;
    req       = 1'b0;
    D_useMDU  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_divu_stall();
    test_req_block();
    test_req_mid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
